// File: rtl/register_set.sv
// Architectural integer register file: 32 x 32-bit, two combinational read
// ports, one synchronous write port, asynchronous clear of the whole file.
module register_set (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [4:0]  ReadAdd1,
  input  logic [4:0]  ReadAdd2,
  input  logic [4:0]  WriteAdd,
  input  logic [31:0] Reg_WriteData,
  output logic [31:0] Data1,
  output logic [31:0] Data2
);

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;

  logic [WIDTH-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0] wr_sel;

  // One-hot write select; x0 is ordinary storage, so every index may be written.
  always_comb begin
    wr_sel = '0;
    if (write_en) begin
      wr_sel[WriteAdd] = 1'b1;
    end
  end

  // Each entry is its own flop bank so the asynchronous clear maps onto
  // per-flop reset pins rather than a RAM macro.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          regs_reg[gi] <= Reg_WriteData;
        end
      end
    end
  endgenerate

  // No write-through: a same-address read returns the old value until the edge.
  assign Data1 = regs_reg[ReadAdd1];
  assign Data2 = regs_reg[ReadAdd2];

endmodule

// File: tb/tb_register_set.sv
// Self-checking bench for register_set: directed cases plus a randomized
// write/read sequence checked against a 32-entry reference array.
module tb_register_set;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [4:0]  ReadAdd1;
  logic [4:0]  ReadAdd2;
  logic [4:0]  WriteAdd;
  logic [31:0] Reg_WriteData;
  logic [31:0] Data1;
  logic [31:0] Data2;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] ref_mem [32];

  register_set dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .ReadAdd1     (ReadAdd1),
    .ReadAdd2     (ReadAdd2),
    .WriteAdd     (WriteAdd),
    .Reg_WriteData(Reg_WriteData),
    .Data1        (Data1),
    .Data2        (Data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      $display("ok   %s observed=%h expected=%h", tag, obs, exp);
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive on negedge, commit on posedge, settle 1 time unit.
  task automatic do_write(input logic en, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_en      = en;
    WriteAdd      = addr;
    Reg_WriteData = data;
    @(posedge clk);
    if (en && !reset) ref_mem[addr] = data;
    #1;
    write_en = 1'b0;
  endtask

  task automatic read_both(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    ReadAdd1 = a1;
    ReadAdd2 = a2;
    #1;
    chk($sformatf("%s p1[%0d]", tag, a1), Data1, ref_mem[a1]);
    chk($sformatf("%s p2[%0d]", tag, a2), Data2, ref_mem[a2]);
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      ReadAdd1 = 5'(i);
      ReadAdd2 = 5'(31 - i);
      #1;
      chk($sformatf("%s p1[%0d]", tag, i), Data1, 32'h0);
      chk($sformatf("%s p2[%0d]", tag, 31 - i), Data2, 32'h0);
    end
  endtask

  initial begin
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] d;
    logic        en;

    reset = 1'b1; write_en = 1'b0; WriteAdd = '0; Reg_WriteData = '0;
    ReadAdd1 = '0; ReadAdd2 = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    sweep_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // Fill with arbitrary contents, then clear asynchronously between edges.
    for (int i = 0; i < 8; i++) do_write(1'b1, 5'($urandom_range(0, 31)), $urandom);
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    #1;
    chk("async_clr_immediate", Data1, 32'h0);
    sweep_zero("rst_sweep");
    @(negedge clk);
    reset = 1'b0;

    // Write/readback plus never-written neighbour.
    do_write(1'b1, 5'd5, 32'hDEADBEEF);
    read_both("wr5", 5'd5, 5'd6);
    chk("wr5_const", Data1, 32'hDEADBEEF);
    chk("rd6_zero", Data2, 32'h0);

    // Disabled write leaves the file untouched.
    do_write(1'b0, 5'd7, 32'h12345678);
    ReadAdd1 = 5'd7; #1;
    chk("wr_disabled_7", Data1, 32'h0);

    // Boundary indices 0 and 31, read simultaneously.
    do_write(1'b1, 5'd0, 32'hA5A5A5A5);
    do_write(1'b1, 5'd31, 32'h5A5A5A5A);
    ReadAdd1 = 5'd0; ReadAdd2 = 5'd31; #1;
    chk("reg0", Data1, 32'hA5A5A5A5);
    chk("reg31", Data2, 32'h5A5A5A5A);

    // Read-during-write: old value before the edge, new value after.
    do_write(1'b1, 5'd3, 32'h11111111);
    @(negedge clk);
    write_en = 1'b1; WriteAdd = 5'd3; Reg_WriteData = 32'h22222222;
    ReadAdd1 = 5'd3; ReadAdd2 = 5'd3;
    #1;
    chk("rdw_before_p1", Data1, 32'h11111111);
    chk("rdw_before_p2", Data2, 32'h11111111);
    @(posedge clk);
    ref_mem[3] = 32'h22222222;
    #1;
    write_en = 1'b0;
    chk("rdw_after_p1", Data1, 32'h22222222);
    do_write(1'b1, 5'd3, 32'h33333333);
    read_both("overwrite3", 5'd3, 5'd5);

    // Randomized regression against the reference array.
    for (int i = 0; i < 40; i++) begin
      a  = 5'($urandom_range(0, 31));
      b  = 5'($urandom_range(0, 31));
      d  = $urandom;
      en = ($urandom_range(0, 3) != 0);
      do_write(en, a, d);
      read_both($sformatf("rnd%0d", i), a, b);
    end

    // Mid-sequence asynchronous reset with write_en held high: reset wins.
    @(negedge clk);
    write_en = 1'b1; WriteAdd = 5'd9; Reg_WriteData = 32'hCAFEF00D;
    #2;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    ReadAdd1 = 5'd3; ReadAdd2 = 5'd5;
    #1;
    chk("mid_rst_p1", Data1, 32'h0);
    chk("mid_rst_p2", Data2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    ReadAdd1 = 5'd9; #1;
    chk("rst_overrides_we", Data1, 32'h0);
    sweep_zero("mid_rst_sweep");
    @(negedge clk);
    write_en = 1'b0;
    reset = 1'b0;

    // First write after deassertion lands on the next enabled edge.
    do_write(1'b1, 5'd9, 32'h0BADC0DE);
    read_both("post_rst", 5'd9, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
